mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem2wbk_fifo.sv | 60 ++++++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage and its output FIFO.
package mem_stage_pkg;

  // Access size encodings carried on MEM_SIZE_RE
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Depth of the MEM->WBK buffer
  localparam int FIFO_DEPTH = 2;

  // Request FSM: accept new work, or hold a stalled cache request
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // One retired instruction headed for writeback (71 bits)
  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  dest;
    logic        wb;
    logic [31:0] pc;
  } entry_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EXE->MEM FIFO, data cache and MEM->WBK FIFO signals.
// slave is the memory stage's view; master is the surrounding pipeline's view.
interface mem_stage_if;

  logic [31:0] EXE_RES_RE;
  logic [31:0] MEM_DATA_RE;
  logic [5:0]  EXE_DEST_RE;
  logic        WB_RE;
  logic        MEM_LOAD_RE;
  logic        MEM_STORE_RE;
  logic [1:0]  MEM_SIZE_RE;
  logic        MEM_SIGN_EXTEND_RE;
  logic [31:0] PC_EXE2MEM_RE;
  logic        EXE2MEM_EMPTY_SE;
  logic        EXE2MEM_POP_SM;

  logic [31:0] MCACHE_ADR_SM;
  logic [31:0] MCACHE_DATA_SM;
  logic        MCACHE_ADR_VALID_SM;
  logic        MCACHE_WRITE_SM;
  logic [3:0]  MCACHE_BYTE_SEL_SM;
  logic [31:0] MCACHE_RESULT_SM;
  logic        MCACHE_STALL_SM;

  logic [31:0] MEM_RES_RM;
  logic [5:0]  MEM_DEST_RM;
  logic        WB_RM;
  logic [31:0] PC_MEM2WBK_RM;
  logic        MEM2WBK_EMPTY_SM;
  logic        MEM2WBK_POP_SW;

  modport slave (
    input  EXE_RES_RE, MEM_DATA_RE, EXE_DEST_RE, WB_RE, MEM_LOAD_RE, MEM_STORE_RE,
           MEM_SIZE_RE, MEM_SIGN_EXTEND_RE, PC_EXE2MEM_RE, EXE2MEM_EMPTY_SE,
           MCACHE_RESULT_SM, MCACHE_STALL_SM, MEM2WBK_POP_SW,
    output EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_ADR_VALID_SM,
           MCACHE_WRITE_SM, MCACHE_BYTE_SEL_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
           PC_MEM2WBK_RM, MEM2WBK_EMPTY_SM
  );

  modport master (
    output EXE_RES_RE, MEM_DATA_RE, EXE_DEST_RE, WB_RE, MEM_LOAD_RE, MEM_STORE_RE,
           MEM_SIZE_RE, MEM_SIGN_EXTEND_RE, PC_EXE2MEM_RE, EXE2MEM_EMPTY_SE,
           MCACHE_RESULT_SM, MCACHE_STALL_SM, MEM2WBK_POP_SW,
    input  EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_ADR_VALID_SM,
           MCACHE_WRITE_SM, MCACHE_BYTE_SEL_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
           PC_MEM2WBK_RM, MEM2WBK_EMPTY_SM
  );

endinterface

// File: rtl/mem2wbk_fifo.sv
// Two-entry in-order buffer between the memory stage and writeback.
module mem2wbk_fifo
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  entry_t     mem_q [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // A pop on an empty buffer is ignored; a push into a full one is dropped
  assign do_push = push_i && (count_q != DEPTH_C);
  assign do_pop  = pop_i && (count_q != 2'd0);

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == DEPTH_C);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; single-bit pointers wrap modulo 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to the data cache, aligns load data,
// and retires every instruction into the MEM->WBK buffer in order.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  // Byte-lane enables; low address bits below the access size are ignored
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  lane_sel = 4'b0001 << lo;
      SIZE_H:  lane_sel = 4'b0011 << {lo[1], 1'b0};
      SIZE_W:  lane_sel = 4'b1111;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  // Replicate store data so every candidate lane carries the operand
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SIZE_B:  store_lanes = {4{d[7:0]}};
      SIZE_H:  store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Pull the addressed byte/half down to bit 0 and extend it
  function automatic logic [31:0] load_align(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lo, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  load_align = sext ? {{24{b[7]}}, b} : {24'd0, b};
      SIZE_H:  load_align = sext ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_align = w;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] adr_q, data_q, pc_q;
  logic [3:0]  bsel_q;
  logic [1:0]  size_q;
  logic [5:0]  dest_q;
  logic        write_q, sext_q, wb_q;

  logic        is_mem, pop_c, push_c, valid_c, write_c, fifo_full, start_wait;
  logic [31:0] adr_c, data_c;
  logic [3:0]  bsel_c;
  entry_t      entry_c, head;

  assign is_mem     = bus.MEM_LOAD_RE || bus.MEM_STORE_RE;
  assign start_wait = (state_q == ST_IDLE) && pop_c && is_mem && bus.MCACHE_STALL_SM;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: park in WAIT while the cache stalls a fresh request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_wait) state_d = ST_WAIT;
      ST_WAIT: if (!bus.MCACHE_STALL_SM) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pop/issue in IDLE, replay held request in WAIT; silent in reset
  always_comb begin
    pop_c   = 1'b0;
    push_c  = 1'b0;
    valid_c = 1'b0;
    adr_c   = {bus.EXE_RES_RE[31:2], 2'b00};
    data_c  = store_lanes(bus.MEM_SIZE_RE, bus.MEM_DATA_RE);
    bsel_c  = lane_sel(bus.MEM_SIZE_RE, bus.EXE_RES_RE[1:0]);
    write_c = bus.MEM_STORE_RE;
    entry_c = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          pop_c = !bus.EXE2MEM_EMPTY_SE && !fifo_full;
          if (pop_c) begin
            valid_c      = is_mem;
            push_c       = !is_mem || !bus.MCACHE_STALL_SM;
            entry_c.dest = bus.EXE_DEST_RE;
            entry_c.pc   = bus.PC_EXE2MEM_RE;
            entry_c.wb   = bus.MEM_STORE_RE ? 1'b0 : bus.WB_RE;
            if (bus.MEM_STORE_RE)
              entry_c.res = 32'd0;
            else if (bus.MEM_LOAD_RE)
              entry_c.res = load_align(bus.MCACHE_RESULT_SM, bus.MEM_SIZE_RE,
                                       bus.EXE_RES_RE[1:0], bus.MEM_SIGN_EXTEND_RE);
            else
              entry_c.res = bus.EXE_RES_RE;
          end
        end
        ST_WAIT: begin
          valid_c      = 1'b1;
          adr_c        = {adr_q[31:2], 2'b00};
          data_c       = data_q;
          bsel_c       = bsel_q;
          write_c      = write_q;
          push_c       = !bus.MCACHE_STALL_SM;
          entry_c.dest = dest_q;
          entry_c.pc   = pc_q;
          entry_c.wb   = write_q ? 1'b0 : wb_q;
          entry_c.res  = write_q ? 32'd0
                                 : load_align(bus.MCACHE_RESULT_SM, size_q, adr_q[1:0], sext_q);
        end
        default: ;
      endcase
    end
  end

  // Capture the stalled request so the cache sees a stable address/data/lanes
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q   <= '0;
      data_q  <= '0;
      bsel_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      dest_q  <= '0;
      wb_q    <= 1'b0;
      pc_q    <= '0;
    end else if (start_wait) begin
      adr_q   <= bus.EXE_RES_RE;
      data_q  <= data_c;
      bsel_q  <= bsel_c;
      write_q <= bus.MEM_STORE_RE;
      size_q  <= bus.MEM_SIZE_RE;
      sext_q  <= bus.MEM_SIGN_EXTEND_RE;
      dest_q  <= bus.EXE_DEST_RE;
      wb_q    <= bus.WB_RE;
      pc_q    <= bus.PC_EXE2MEM_RE;
    end
  end

  mem2wbk_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .entry_i (entry_c),
    .pop_i   (bus.MEM2WBK_POP_SW),
    .head_o  (head),
    .empty_o (bus.MEM2WBK_EMPTY_SM),
    .full_o  (fifo_full)
  );

  assign bus.EXE2MEM_POP_SM      = pop_c;
  assign bus.MCACHE_ADR_VALID_SM = valid_c;
  assign bus.MCACHE_ADR_SM       = adr_c;
  assign bus.MCACHE_DATA_SM      = data_c;
  assign bus.MCACHE_BYTE_SEL_SM  = bsel_c;
  assign bus.MCACHE_WRITE_SM     = write_c;
  assign bus.MEM_RES_RM          = head.res;
  assign bus.MEM_DEST_RM         = head.dest;
  assign bus.WB_RM               = head.wb;
  assign bus.PC_MEM2WBK_RM       = head.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scenarios followed by a randomized run against a transaction-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  dest;
    logic        wb;
    logic [31:0] pc;
  } ment_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.EXE_RES_RE = '0; bus.MEM_DATA_RE = '0; bus.EXE_DEST_RE = '0; bus.WB_RE = 1'b0;
    bus.MEM_LOAD_RE = 1'b0; bus.MEM_STORE_RE = 1'b0; bus.MEM_SIZE_RE = 2'b10;
    bus.MEM_SIGN_EXTEND_RE = 1'b0; bus.PC_EXE2MEM_RE = '0; bus.EXE2MEM_EMPTY_SE = 1'b1;
    bus.MCACHE_RESULT_SM = '0; bus.MCACHE_STALL_SM = 1'b0; bus.MEM2WBK_POP_SW = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] res, input logic [31:0] data, input logic [5:0] dest,
                        input logic wb, input logic ld, input logic st, input logic [1:0] sz,
                        input logic sx, input logic [31:0] pc);
    bus.EXE_RES_RE = res; bus.MEM_DATA_RE = data; bus.EXE_DEST_RE = dest; bus.WB_RE = wb;
    bus.MEM_LOAD_RE = ld; bus.MEM_STORE_RE = st; bus.MEM_SIZE_RE = sz;
    bus.MEM_SIGN_EXTEND_RE = sx; bus.PC_EXE2MEM_RE = pc; bus.EXE2MEM_EMPTY_SE = 1'b0;
  endtask

  task automatic wbk_pop();
    bus.MEM2WBK_POP_SW = 1'b1;
    tick();
    bus.MEM2WBK_POP_SW = 1'b0;
  endtask

  // Reference rules written as plain arithmetic on the address and word
  function automatic logic [31:0] m_bsel(input logic [1:0] sz, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (sz == 2'b00) return 32'(1 << lo);
    if (sz == 2'b01) return 32'(3 << ((lo / 2) * 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_data(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [31:0] a, input logic sx);
    logic [31:0] v;
    int lo;
    lo = int'(a % 4);
    if (sz == 2'b00) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'b01) begin
      v = (w >> (16 * (lo / 2))) & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ment_t q[$];
    ment_t e;
    bit busy;
    bit have_push;
    bit exp_pop, exp_valid;
    logic [31:0] p_adr, p_data, p_pc, s_adr, s_data;
    logic [1:0]  p_sz, s_sz;
    logic        p_sx, p_st, p_wb, s_st;
    logic [5:0]  p_dest;
    int kind;

    // ---- reset, with a pending ALU op upstream that must not be popped
    idle_in();
    reset = 1'b1;
    set_op(32'h55, 32'h0, 6'd1, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h10);
    tick(); tick();
    chk("rst_pop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
    chk("rst_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
    chk("rst_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);
    chk("rst_res", bus.MEM_RES_RM, 32'd0);
    reset = 1'b0;
    idle_in();
    tick();

    // ---- ALU op
    set_op(32'h1234, 32'h0, 6'd5, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h100);
    #1;
    chk("alu_pop", 32'(bus.EXE2MEM_POP_SM), 32'd1);
    chk("alu_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
    chk("alu_empty_same", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);
    tick();
    idle_in();
    #1;
    chk("alu_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd0);
    chk("alu_res", bus.MEM_RES_RM, 32'h1234);
    chk("alu_dest", 32'(bus.MEM_DEST_RM), 32'd5);
    chk("alu_wb", 32'(bus.WB_RM), 32'd1);
    chk("alu_pc", bus.PC_MEM2WBK_RM, 32'h100);
    wbk_pop();
    #1;
    chk("alu_drained", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);

    // ---- signed and unsigned byte load from lane 3
    for (int sx = 1; sx >= 0; sx--) begin
      set_op(32'h1003, 32'h0, 6'd7, 1'b1, 1'b1, 1'b0, SIZE_B, sx[0], 32'h104);
      bus.MCACHE_RESULT_SM = 32'h80FF_0011;
      #1;
      chk("ldb_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
      chk("ldb_adr", bus.MCACHE_ADR_SM, 32'h1000);
      chk("ldb_bsel", 32'(bus.MCACHE_BYTE_SEL_SM), 32'b1000);
      chk("ldb_write", 32'(bus.MCACHE_WRITE_SM), 32'd0);
      tick();
      idle_in();
      #1;
      chk("ldb_res", bus.MEM_RES_RM, (sx == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("ldb_dest", 32'(bus.MEM_DEST_RM), 32'd7);
      wbk_pop();
    end

    // ---- half store held under a 3-cycle stall while upstream changes
    set_op(32'h2002, 32'h0000_ABCD, 6'd9, 1'b1, 1'b0, 1'b1, SIZE_H, 1'b0, 32'h108);
    bus.MCACHE_STALL_SM = 1'b1;
    #1;
    chk("sth_pop", 32'(bus.EXE2MEM_POP_SM), 32'd1);
    chk("sth_bsel0", 32'(bus.MCACHE_BYTE_SEL_SM), 32'b1100);
    chk("sth_data0", bus.MCACHE_DATA_SM, 32'hABCD_ABCD);
    chk("sth_write0", 32'(bus.MCACHE_WRITE_SM), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_op(32'h3001, 32'h5555, 6'd3, 1'b1, 1'b1, 1'b0, SIZE_B, 1'b1, 32'h200);
      bus.MCACHE_STALL_SM = (k < 2);
      #1;
      chk("sth_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
      chk("sth_adr", bus.MCACHE_ADR_SM, 32'h2000);
      chk("sth_bsel", 32'(bus.MCACHE_BYTE_SEL_SM), 32'b1100);
      chk("sth_data", bus.MCACHE_DATA_SM, 32'hABCD_ABCD);
      chk("sth_write", 32'(bus.MCACHE_WRITE_SM), 32'd1);
      chk("sth_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
      chk("sth_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);
      tick();
    end
    idle_in();
    #1;
    chk("sth_pushed", 32'(bus.MEM2WBK_EMPTY_SM), 32'd0);
    chk("sth_wb", 32'(bus.WB_RM), 32'd0);
    chk("sth_res", bus.MEM_RES_RM, 32'd0);
    chk("sth_pc", bus.PC_MEM2WBK_RM, 32'h108);
    wbk_pop();
    #1;
    chk("sth_single", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);

    // ---- backpressure: three ALU ops, WBK idle
    set_op(32'h11, 32'h0, 6'd1, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h300);
    #1; chk("bp_pop1", 32'(bus.EXE2MEM_POP_SM), 32'd1);
    tick();
    set_op(32'h22, 32'h0, 6'd2, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h304);
    #1; chk("bp_pop2", 32'(bus.EXE2MEM_POP_SM), 32'd1);
    tick();
    set_op(32'h33, 32'h0, 6'd3, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h308);
    #1;
    chk("bp_full_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
    chk("bp_head1", bus.MEM_RES_RM, 32'h11);
    tick();
    #1;
    chk("bp_still_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
    bus.MEM2WBK_POP_SW = 1'b1;
    #1;
    chk("bp_no_bypass", 32'(bus.EXE2MEM_POP_SM), 32'd0);
    tick();
    bus.MEM2WBK_POP_SW = 1'b0;
    #1;
    chk("bp_accept3", 32'(bus.EXE2MEM_POP_SM), 32'd1);
    chk("bp_head2", bus.MEM_RES_RM, 32'h22);
    tick();
    idle_in();
    #1;
    chk("bp_head2b", bus.MEM_RES_RM, 32'h22);
    wbk_pop();
    #1;
    chk("bp_head3", bus.MEM_RES_RM, 32'h33);
    chk("bp_pc3", bus.PC_MEM2WBK_RM, 32'h308);
    wbk_pop();
    #1;
    chk("bp_drained", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);

    // ---- reset while a load is stalled
    set_op(32'h4000, 32'h0, 6'd4, 1'b1, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h400);
    bus.MCACHE_STALL_SM = 1'b1;
    bus.MCACHE_RESULT_SM = 32'hDEAD_BEEF;
    tick();
    idle_in();
    bus.MCACHE_STALL_SM = 1'b1;
    #1;
    chk("rw_waiting", 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
    reset = 1'b1;
    tick();
    chk("rw_valid_in_rst", 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
    reset = 1'b0;
    bus.MCACHE_STALL_SM = 1'b0;
    #1;
    chk("rw_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);
    chk("rw_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
    chk("rw_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick();
    #1;
    chk("rw_no_push", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);

    // ---- randomized traffic against the transaction model
    busy = 1'b0;
    p_adr = '0; p_data = '0; p_pc = '0; p_sz = '0; p_sx = 1'b0; p_st = 1'b0;
    p_wb = 1'b0; p_dest = '0;
    for (int c = 0; c < 600; c++) begin
      kind = int'($urandom_range(0, 2));
      set_op($urandom, $urandom, 6'($urandom), 1'($urandom), kind == 1, kind == 2,
             2'($urandom_range(0, 2)), 1'($urandom), $urandom);
      bus.EXE2MEM_EMPTY_SE = ($urandom_range(0, 3) == 0);
      bus.MCACHE_STALL_SM  = ($urandom_range(0, 2) == 0);
      bus.MCACHE_RESULT_SM = $urandom;
      bus.MEM2WBK_POP_SW   = 1'($urandom);
      #1;

      exp_pop = !busy && !bus.EXE2MEM_EMPTY_SE && (q.size() < 2);
      chk("r_pop", 32'(bus.EXE2MEM_POP_SM), 32'(exp_pop));
      chk("r_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'(q.size() == 0));
      if (q.size() > 0) begin
        chk("r_res", bus.MEM_RES_RM, q[0].res);
        chk("r_dest", 32'(bus.MEM_DEST_RM), 32'(q[0].dest));
        chk("r_wb", 32'(bus.WB_RM), 32'(q[0].wb));
        chk("r_pc", bus.PC_MEM2WBK_RM, q[0].pc);
      end
      exp_valid = busy || (exp_pop && (kind != 0));
      chk("r_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'(exp_valid));
      if (exp_valid) begin
        s_adr  = busy ? p_adr : bus.EXE_RES_RE;
        s_sz   = busy ? p_sz : bus.MEM_SIZE_RE;
        s_st   = busy ? p_st : bus.MEM_STORE_RE;
        s_data = busy ? p_data : bus.MEM_DATA_RE;
        chk("r_adr", bus.MCACHE_ADR_SM, s_adr & ~32'd3);
        chk("r_bsel", 32'(bus.MCACHE_BYTE_SEL_SM), m_bsel(s_sz, s_adr));
        chk("r_write", 32'(bus.MCACHE_WRITE_SM), 32'(s_st));
        if (s_st) chk("r_data", bus.MCACHE_DATA_SM, m_data(s_sz, s_data));
      end

      have_push = 1'b0;
      if (busy) begin
        if (!bus.MCACHE_STALL_SM) begin
          e.res  = p_st ? 32'd0 : m_load(bus.MCACHE_RESULT_SM, p_sz, p_adr, p_sx);
          e.dest = p_dest;
          e.wb   = p_st ? 1'b0 : p_wb;
          e.pc   = p_pc;
          have_push = 1'b1;
          busy = 1'b0;
        end
      end else if (exp_pop) begin
        if (kind != 0 && bus.MCACHE_STALL_SM) begin
          busy = 1'b1;
          p_adr = bus.EXE_RES_RE; p_data = bus.MEM_DATA_RE; p_sz = bus.MEM_SIZE_RE;
          p_sx = bus.MEM_SIGN_EXTEND_RE; p_st = (kind == 2); p_wb = bus.WB_RE;
          p_dest = bus.EXE_DEST_RE; p_pc = bus.PC_EXE2MEM_RE;
        end else begin
          if (kind == 0)      e.res = bus.EXE_RES_RE;
          else if (kind == 2) e.res = 32'd0;
          else e.res = m_load(bus.MCACHE_RESULT_SM, bus.MEM_SIZE_RE, bus.EXE_RES_RE,
                              bus.MEM_SIGN_EXTEND_RE);
          e.dest = bus.EXE_DEST_RE;
          e.wb   = (kind == 2) ? 1'b0 : bus.WB_RE;
          e.pc   = bus.PC_EXE2MEM_RE;
          have_push = 1'b1;
        end
      end
      if (bus.MEM2WBK_POP_SW && q.size() > 0) void'(q.pop_front());
      if (have_push) q.push_back(e);
      tick();
    end

    idle_in();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
